axi_ram_slave: RTL and testbench

- AXI4 memory-mapped slave RAM model. Independent write channels (AW/W/B) and read channel (AR/R).
- Serves as the DDR/memory stub behind the prefetcher's master port in system benches.
- Supports single and burst accesses, byte strobes, and an optional registered read output.

---
 rtl/axi_ram_slave_pkg.sv | 54 +++++
 rtl/axi_ram_slave_rd_pipe.sv | 44 ++++
 rtl/axi_ram_slave.sv | 242 ++++++++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ram_slave_pkg.sv
// Shared types and burst address helper for the AXI4 RAM slave.
// WRAP bursts are honoured only when AXI_RAM_SLAVE_WRAP_BURST_EN is defined.
package axi_ram_slave_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

`ifdef AXI_RAM_SLAVE_WRAP_BURST_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        W_IDLE,
        W_BURST,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } r_state_t;

    // INCR realigns to the beat size; WRAP stays inside (len+1)<<size.
    function automatic logic [63:0] next_addr(
        input logic [63:0] addr,
        input logic [2:0]  size,
        input logic [7:0]  len,
        input logic [1:0]  burst
    );
        logic [63:0] incr;
        logic [63:0] base;
        logic [63:0] sum;
        logic [63:0] mask;
        logic [63:0] wrapped;
        incr    = 64'd1 << size;
        base    = addr & ~(incr - 64'd1);
        sum     = base + incr;
        mask    = ((64'(len) + 64'd1) << size) - 64'd1;
        wrapped = (addr & ~mask) | (sum & mask);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = WRAP_EN ? wrapped : sum;
            default:     next_addr = sum;
        endcase
    endfunction

endpackage

// File: rtl/axi_ram_slave_rd_pipe.sv
// R-channel register slice with one skid entry.
// Adds one cycle of latency while keeping one beat per cycle.
module axi_ram_slave_rd_pipe #(
    parameter int WIDTH = 41
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    assign in_ready = !skid_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (out_ready || !out_valid) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_data <= in_data;
                end
            end
        end else if (in_valid && in_ready) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 RAM slave with independent write (AW/W/B) and read (AR/R) engines.
// Define AXI_RAM_SLAVE_WRAP_BURST_EN to enable WRAP bursts (else as INCR).
module axi_ram_slave
    import axi_ram_slave_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int ID_WIDTH        = 8,
    parameter int PIPELINE_OUTPUT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int ADDR_LSB         = $clog2(STRB_WIDTH);
    localparam int VALID_ADDR_WIDTH = ADDR_WIDTH - ADDR_LSB;
    localparam int R_WIDTH          = ID_WIDTH + DATA_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [2**VALID_ADDR_WIDTH];

    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        clamp_size = (size > 3'(ADDR_LSB)) ? 3'(ADDR_LSB) : size;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] advance(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [2:0]            size,
        input logic [7:0]            len,
        input logic [1:0]            burst
    );
        advance = ADDR_WIDTH'(next_addr(64'(addr), size, len, burst));
    endfunction

    function automatic logic [VALID_ADDR_WIDTH-1:0] word(
        input logic [ADDR_WIDTH-1:0] addr
    );
        word = VALID_ADDR_WIDTH'(addr >> ADDR_LSB);
    endfunction

    logic unused_sideband;
    assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot,
                               s_axi_arlock, s_axi_arcache, s_axi_arprot,
                               s_axi_wlast};

    assign s_axi_bresp = RESP_OKAY;
    assign s_axi_rresp = RESP_OKAY;

    w_state_t              w_state;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [7:0]            w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            w_addr        <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_size        <= '0;
            w_burst       <= '0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (s_axi_awvalid) begin
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        s_axi_bid     <= s_axi_awid;
                        w_addr        <= s_axi_awaddr;
                        w_len         <= s_axi_awlen;
                        w_cnt         <= s_axi_awlen;
                        w_size        <= clamp_size(s_axi_awsize);
                        w_burst       <= s_axi_awburst;
                        w_state       <= W_BURST;
                    end
                end
                W_BURST: begin
                    if (s_axi_wvalid) begin
                        w_addr <= advance(w_addr, w_size, w_len, w_burst);
                        if (w_cnt == 8'd0) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            w_state      <= W_RESP;
                        end else begin
                            w_cnt <= w_cnt - 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (!rst && w_state == W_BURST && s_axi_wvalid) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_axi_wstrb[i]) begin
                    mem[word(w_addr)][8*i +: 8] <= s_axi_wdata[8*i +: 8];
                end
            end
        end
    end

    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_next;
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_valid;
    logic                  r_last;
    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  core_ready;

    assign r_next = advance(r_addr, r_size, r_len, r_burst);

    // Data is fetched one edge ahead, so a colliding write returns old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b1;
            r_valid       <= 1'b0;
            r_last        <= 1'b0;
            r_id          <= '0;
            r_data        <= '0;
            r_addr        <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_size        <= '0;
            r_burst       <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (s_axi_arvalid) begin
                        s_axi_arready <= 1'b0;
                        r_valid       <= 1'b1;
                        r_id          <= s_axi_arid;
                        r_addr        <= s_axi_araddr;
                        r_len         <= s_axi_arlen;
                        r_cnt         <= s_axi_arlen;
                        r_size        <= clamp_size(s_axi_arsize);
                        r_burst       <= s_axi_arburst;
                        r_data        <= mem[word(s_axi_araddr)];
                        r_last        <= (s_axi_arlen == 8'd0);
                        r_state       <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (core_ready) begin
                        if (r_cnt == 8'd0) begin
                            r_valid       <= 1'b0;
                            r_last        <= 1'b0;
                            s_axi_arready <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            r_addr <= r_next;
                            r_data <= mem[word(r_next)];
                            r_cnt  <= r_cnt - 8'd1;
                            r_last <= (r_cnt == 8'd1);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    if (PIPELINE_OUTPUT != 0) begin : g_pipe
        logic [R_WIDTH-1:0] out_bus;
        axi_ram_slave_rd_pipe #(
            .WIDTH(R_WIDTH)
        ) u_rd_pipe (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (r_valid),
            .in_ready  (core_ready),
            .in_data   ({r_id, r_data, r_last}),
            .out_valid (s_axi_rvalid),
            .out_ready (s_axi_rready),
            .out_data  (out_bus)
        );
        assign {s_axi_rid, s_axi_rdata, s_axi_rlast} = out_bus;
    end else begin : g_direct
        assign core_ready   = s_axi_rready;
        assign s_axi_rvalid = r_valid;
        assign s_axi_rid    = r_id;
        assign s_axi_rdata  = r_data;
        assign s_axi_rlast  = r_last;
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Bench for axi_ram_slave: direct and pipelined R paths side by side.
// Shared stimulus; per-DUT read scoreboards fed from a word model.
module tb_axi_ram_slave;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int IW = 8;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [IW-1:0] awid, arid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst;
    logic          awvalid, arvalid;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wlast, wvalid, bready, rready;

    logic          awready [2];
    logic          wready  [2];
    logic          bvalid  [2];
    logic          arready [2];
    logic          rvalid  [2];
    logic          rlast   [2];
    logic [IW-1:0] bid     [2];
    logic [IW-1:0] rid     [2];
    logic [1:0]    bresp   [2];
    logic [1:0]    rresp   [2];
    logic [DW-1:0] rdata   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_ram_slave #(
            .DATA_WIDTH      (DW),
            .ADDR_WIDTH      (AW),
            .ID_WIDTH        (IW),
            .PIPELINE_OUTPUT (g)
        ) dut (
            .clk           (clk),
            .rst           (rst),
            .s_axi_awid    (awid),
            .s_axi_awaddr  (awaddr),
            .s_axi_awlen   (awlen),
            .s_axi_awsize  (awsize),
            .s_axi_awburst (awburst),
            .s_axi_awlock  (1'b0),
            .s_axi_awcache (4'd0),
            .s_axi_awprot  (3'd0),
            .s_axi_awvalid (awvalid),
            .s_axi_awready (awready[g]),
            .s_axi_wdata   (wdata),
            .s_axi_wstrb   (wstrb),
            .s_axi_wlast   (wlast),
            .s_axi_wvalid  (wvalid),
            .s_axi_wready  (wready[g]),
            .s_axi_bid     (bid[g]),
            .s_axi_bresp   (bresp[g]),
            .s_axi_bvalid  (bvalid[g]),
            .s_axi_bready  (bready),
            .s_axi_arid    (arid),
            .s_axi_araddr  (araddr),
            .s_axi_arlen   (arlen),
            .s_axi_arsize  (arsize),
            .s_axi_arburst (arburst),
            .s_axi_arlock  (1'b0),
            .s_axi_arcache (4'd0),
            .s_axi_arprot  (3'd0),
            .s_axi_arvalid (arvalid),
            .s_axi_arready (arready[g]),
            .s_axi_rid     (rid[g]),
            .s_axi_rdata   (rdata[g]),
            .s_axi_rresp   (rresp[g]),
            .s_axi_rlast   (rlast[g]),
            .s_axi_rvalid  (rvalid[g]),
            .s_axi_rready  (rready)
        );
    end

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [7:0]  id;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] model [16384];
    logic [31:0] wbeats [16];
    logic [3:0]  wstrbs [16];
    logic        stalled [2];
    logic [31:0] held [2];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] tb_next(input logic [15:0] a,
                                            input int bytes,
                                            input int beats,
                                            input logic [1:0] burst);
        int region;
        int base;
        if (burst == 2'b00) return a;
`ifdef AXI_RAM_SLAVE_WRAP_BURST_EN
        if (burst == 2'b10) begin
            region = bytes * beats;
            base   = int'(a) - int'(a) % region;
            return 16'(base + (int'(a) - base + bytes) % region);
        end
`endif
        return 16'(int'(a) - int'(a) % bytes + bytes);
    endfunction

    // Inputs only change at posedge+1, so the negedge view is the handshake.
    task automatic mon(input int k);
        exp_t e;
        if (rst) begin
            stalled[k] = 1'b0;
            return;
        end
        if (stalled[k]) begin
            check($sformatf("r_hold_valid%0d", k), rvalid[k], 1'b1);
            check($sformatf("r_hold_data%0d", k), rdata[k], held[k]);
        end
        stalled[k] = rvalid[k] && !rready;
        held[k]    = rdata[k];
        if (rvalid[k] && rready) begin
            if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                check($sformatf("r_extra_beat%0d", k), rvalid[k], 1'b0);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("rdata%0d", k), rdata[k], e.data);
                check($sformatf("rlast%0d", k), rlast[k], e.last);
                check($sformatf("rid%0d", k), rid[k], e.id);
                check($sformatf("rresp%0d", k), rresp[k], 2'b00);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic push_exp(input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [7:0] id);
        logic [15:0] a;
        exp_t        e;
        int          bytes;
        a     = addr;
        bytes = 1 << ((size > 3'd2) ? 2 : int'(size));
        for (int i = 0; i <= int'(len); i++) begin
            e.data = model[a[15:2]];
            e.last = (i == int'(len));
            e.id   = id;
            q0.push_back(e);
            q1.push_back(e);
            a = tb_next(a, bytes, int'(len) + 1, burst);
        end
    endtask

    task automatic axi_write(input logic [15:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [7:0] id);
        logic [15:0] a;
        int          bytes;
        a       = addr;
        bytes   = 1 << ((size > 3'd2) ? 2 : int'(size));
        awid    = id;
        awaddr  = addr;
        awlen   = len;
        awsize  = size;
        awburst = burst;
        awvalid = 1'b1;
        @(negedge clk);
        check("awready0", awready[0], 1'b1);
        check("awready1", awready[1], 1'b1);
        step();
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata  = wbeats[i];
            wstrb  = wstrbs[i];
            wlast  = (i == int'(len));
            wvalid = 1'b1;
            @(negedge clk);
            check("wready0", wready[0], 1'b1);
            check("wready1", wready[1], 1'b1);
            for (int b = 0; b < 4; b++) begin
                if (wstrbs[i][b]) model[a[15:2]][8*b +: 8] = wbeats[i][8*b +: 8];
            end
            a = tb_next(a, bytes, int'(len) + 1, burst);
            step();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("bvalid%0d", k), bvalid[k], 1'b1);
            check($sformatf("bid%0d", k), bid[k], id);
            check($sformatf("bresp%0d", k), bresp[k], 2'b00);
            check($sformatf("wready_done%0d", k), wready[k], 1'b0);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("bvalid_clr%0d", k), bvalid[k], 1'b0);
            check($sformatf("awready_back%0d", k), awready[k], 1'b1);
        end
        step();
    endtask

    task automatic axi_read(input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [7:0] id, input int stall_at);
        push_exp(addr, len, size, burst, id);
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arsize  = size;
        arburst = burst;
        arvalid = 1'b1;
        rready  = 1'b1;
        @(negedge clk);
        check("arready0", arready[0], 1'b1);
        check("arready1", arready[1], 1'b1);
        step();
        arvalid = 1'b0;
        @(negedge clk);
        check("rvalid_lat0", rvalid[0], 1'b1);
        check("rvalid_lat1", rvalid[1], 1'b0);
        check("arready_busy", arready[0], 1'b0);
        for (int n = 0; n < 200 && (q0.size() != 0 || q1.size() != 0); n++) begin
            step();
            rready = !(stall_at >= 0 && n >= stall_at && n < stall_at + 3);
        end
        rready = 1'b1;
        check("rd_drain", q0.size() + q1.size(), 0);
        @(negedge clk);
        check("arready_idle0", arready[0], 1'b1);
        check("arready_idle1", arready[1], 1'b1);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
        wvalid = 1'b0; bready = 1'b0; arid = '0; araddr = '0;
        arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            stalled[k] = 1'b0;
            held[k]    = '0;
        end
        for (int i = 0; i < 16; i++) wstrbs[i] = 4'hF;

        repeat (3) step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_awready%0d", k), awready[k], 1'b1);
            check($sformatf("rst_arready%0d", k), arready[k], 1'b1);
            check($sformatf("rst_wready%0d", k), wready[k], 1'b0);
            check($sformatf("rst_bvalid%0d", k), bvalid[k], 1'b0);
            check($sformatf("rst_rvalid%0d", k), rvalid[k], 1'b0);
            check($sformatf("rst_rlast%0d", k), rlast[k], 1'b0);
            check($sformatf("rst_bid%0d", k), bid[k], 8'd0);
            check($sformatf("rst_rid%0d", k), rid[k], 8'd0);
            check($sformatf("rst_rdata%0d", k), rdata[k], 32'd0);
            check($sformatf("rst_resp%0d", k), {bresp[k], rresp[k]}, 4'd0);
        end
        step();
        rst = 1'b0;
        rready = 1'b1;

        // Single beat, ID echo
        wbeats[0] = 32'h0000_0001;
        axi_write(16'h0004, 8'd0, 3'd2, 2'b01, 8'd5);
        axi_read(16'h0004, 8'd0, 3'd2, 2'b01, 8'd5, -1);

        // INCR burst of four
        wbeats[0] = 32'hA; wbeats[1] = 32'hB;
        wbeats[2] = 32'hC; wbeats[3] = 32'hD;
        axi_write(16'h0000, 8'd3, 3'd2, 2'b01, 8'd1);
        axi_read(16'h0000, 8'd3, 3'd2, 2'b01, 8'd2, -1);

        // Eight beats with a three-cycle rready stall mid-burst
        for (int i = 0; i < 8; i++) wbeats[i] = 32'h1111_0000 * (i + 1) + 32'(i);
        axi_write(16'h0040, 8'd7, 3'd2, 2'b01, 8'd3);
        axi_read(16'h0040, 8'd7, 3'd2, 2'b01, 8'd4, 3);

        // Byte strobes
        wbeats[0] = 32'h1122_3344;
        axi_write(16'h0100, 8'd0, 3'd2, 2'b01, 8'd6);
        wbeats[0] = 32'hFFFF_FFFF; wstrbs[0] = 4'b0000;
        axi_write(16'h0100, 8'd0, 3'd2, 2'b01, 8'd6);
        wstrbs[0] = 4'b0101;
        axi_write(16'h0100, 8'd0, 3'd2, 2'b01, 8'd6);
        wstrbs[0] = 4'hF;
        axi_read(16'h0100, 8'd0, 3'd2, 2'b01, 8'd7, -1);

        // Oversized beat size is clamped to the bus width
        wbeats[0] = 32'hCAFE_0001; wbeats[1] = 32'hCAFE_0002;
        axi_write(16'h0200, 8'd1, 3'd5, 2'b01, 8'd8);
        axi_read(16'h0200, 8'd1, 3'd2, 2'b01, 8'd8, -1);
        axi_read(16'h0200, 8'd1, 3'd7, 2'b01, 8'd9, -1);

        // Address wraps past the top of the space
        wbeats[0] = 32'hEEEE_0001; wbeats[1] = 32'hEEEE_0002;
        axi_write(16'hFFFC, 8'd1, 3'd2, 2'b01, 8'd10);
        axi_read(16'hFFFC, 8'd1, 3'd2, 2'b01, 8'd11, -1);

        // FIXED burst, burst code 11 treated as INCR
        wbeats[0] = 32'h5; wbeats[1] = 32'h6;
        axi_write(16'h0000, 8'd1, 3'd2, 2'b00, 8'd12);
        axi_read(16'h0000, 8'd2, 3'd2, 2'b00, 8'd13, -1);
        axi_read(16'h0040, 8'd2, 3'd2, 2'b11, 8'd14, 1);

        // WRAP len 3 starting at word 2 of a 16-byte region
        for (int i = 0; i < 6; i++) wbeats[i] = 32'h3000_0000 + 32'(i);
        axi_write(16'h0300, 8'd5, 3'd2, 2'b01, 8'd15);
        axi_read(16'h0308, 8'd3, 3'd2, 2'b10, 8'd16, -1);

        // Reset after two beats of a four-beat read
        push_exp(16'h0040, 8'd3, 3'd2, 2'b01, 8'd17);
        arid = 8'd17; araddr = 16'h0040; arlen = 8'd3;
        arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        for (int n = 0; n < 20 && q0.size() > 2; n++) step();
        check("rst_wait", q0.size(), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("abort_rvalid%0d", k), rvalid[k], 1'b0);
            check($sformatf("abort_arready%0d", k), arready[k], 1'b1);
        end
        step();
        axi_read(16'h0040, 8'd3, 3'd2, 2'b01, 8'd18, -1);
        axi_read(16'h0100, 8'd0, 3'd2, 2'b01, 8'd19, -1);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
